// File: rtl/decode_stage.sv
// RV64I decode/issue stage: instruction decode, immediate generation, operand bypass,
// register scoreboard with RAW/WAW stalls, and the DE->EX pipeline register.
module decode_stage #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NREG = 32
) (
  input  logic            CLK,
  input  logic            reset_n,
  input  logic            FE_V,
  input  logic [31:0]     FE_IR,
  input  logic [XLEN-1:0] FE_PC,
  output logic            DE_STALL,
  output logic [4:0]      SR1,
  output logic [4:0]      SR2,
  input  logic [XLEN-1:0] RF_ONE,
  input  logic [XLEN-1:0] RF_TWO,
  input  logic            WB_V,
  input  logic [4:0]      WB_DR,
  input  logic [XLEN-1:0] WB_DATA,
  input  logic            EX_STALL,
  input  logic            FLUSH,
  output logic            EX_V,
  output logic [XLEN-1:0] EX_PC,
  output logic [31:0]     EX_IR,
  output logic [XLEN-1:0] EX_OP1,
  output logic [XLEN-1:0] EX_OP2,
  output logic [XLEN-1:0] EX_IMM,
  output logic [4:0]      EX_DR,
  output logic            EX_WE
);

  localparam int unsigned RW = 5;

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;
  logic            w_u1, w_u2, w_wr;
  logic [XLEN-1:0] w_imm;
  logic [RW-1:0]   w_rs1, w_rs2, w_rd;
  logic            w_we;
  logic [XLEN-1:0] w_op1, w_op2;
  logic            w_rdy1, w_rdy2, w_rdyd;
  logic            w_hazard, w_fire;

  assign w_rs1 = FE_IR[19:15];
  assign w_rs2 = FE_IR[24:20];
  assign w_rd  = FE_IR[11:7];
  assign SR1   = w_rs1;
  assign SR2   = w_rs2;

  // Opcode decode: register usage and sign-extended immediate
  always_comb begin
    w_u1  = 1'b0;
    w_u2  = 1'b0;
    w_wr  = 1'b0;
    w_imm = '0;
    unique case (FE_IR[6:0])
      7'b0110111, 7'b0010111: begin
        w_wr  = 1'b1;
        w_imm = XLEN'($signed({FE_IR[31:12], 12'b0}));
      end
      7'b1101111: begin
        w_wr  = 1'b1;
        w_imm = XLEN'($signed({FE_IR[31], FE_IR[19:12], FE_IR[20], FE_IR[30:21], 1'b0}));
      end
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0011011: begin
        w_u1  = 1'b1;
        w_wr  = 1'b1;
        w_imm = XLEN'($signed(FE_IR[31:20]));
      end
      7'b1100011: begin
        w_u1  = 1'b1;
        w_u2  = 1'b1;
        w_imm = XLEN'($signed({FE_IR[31], FE_IR[7], FE_IR[30:25], FE_IR[11:8], 1'b0}));
      end
      7'b0100011: begin
        w_u1  = 1'b1;
        w_u2  = 1'b1;
        w_imm = XLEN'($signed({FE_IR[31:25], FE_IR[11:7]}));
      end
      7'b0110011, 7'b0111011: begin
        w_u1 = 1'b1;
        w_u2 = 1'b1;
        w_wr = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_we = w_wr & (w_rd != '0);

  // A writeback landing this edge makes its register ready and supplies the operand
  assign w_rdy1 = !r_busy[w_rs1] | (WB_V & (WB_DR == w_rs1));
  assign w_rdy2 = !r_busy[w_rs2] | (WB_V & (WB_DR == w_rs2));
  assign w_rdyd = !r_busy[w_rd]  | (WB_V & (WB_DR == w_rd));

  always_comb begin
    w_op1 = '0;
    w_op2 = '0;
    if (w_u1 && w_rs1 != '0)
      w_op1 = (WB_V && WB_DR == w_rs1) ? WB_DATA : RF_ONE;
    if (w_u2 && w_rs2 != '0)
      w_op2 = (WB_V && WB_DR == w_rs2) ? WB_DATA : RF_TWO;
  end

  assign w_hazard = (w_u1 & (w_rs1 != '0) & !w_rdy1)
                  | (w_u2 & (w_rs2 != '0) & !w_rdy2)
                  | (w_we & !w_rdyd);
  assign w_fire   = FE_V & !EX_STALL & !FLUSH & !w_hazard;
  assign DE_STALL = FE_V & !FLUSH & (EX_STALL | w_hazard);

  // Scoreboard: clear on writeback, then set for the issuing writer (set wins)
  always_comb begin
    w_busy_nxt = r_busy;
    if (WB_V) w_busy_nxt[WB_DR] = 1'b0;
    if (w_fire && w_we) w_busy_nxt[w_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) r_busy <= '0;
    else          r_busy <= w_busy_nxt;
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      EX_V   <= 1'b0;
      EX_PC  <= '0;
      EX_IR  <= '0;
      EX_OP1 <= '0;
      EX_OP2 <= '0;
      EX_IMM <= '0;
      EX_DR  <= '0;
      EX_WE  <= 1'b0;
    end else if (EX_STALL) begin
      EX_V <= EX_V;
    end else if (w_fire) begin
      EX_V   <= 1'b1;
      EX_PC  <= FE_PC;
      EX_IR  <= FE_IR;
      EX_OP1 <= w_op1;
      EX_OP2 <= w_op2;
      EX_IMM <= w_imm;
      EX_DR  <= w_rd;
      EX_WE  <= w_we;
    end else begin
      EX_V   <= 1'b0;
      EX_PC  <= '0;
      EX_IR  <= '0;
      EX_OP1 <= '0;
      EX_OP2 <= '0;
      EX_IMM <= '0;
      EX_DR  <= '0;
      EX_WE  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, RAW/WAW stalls, bypass, x0, immediates, EX_STALL, FLUSH.
module tb_decode_stage;

  logic        CLK = 1'b0;
  logic        reset_n;
  logic        FE_V;
  logic [31:0] FE_IR;
  logic [63:0] FE_PC;
  logic        DE_STALL;
  logic [4:0]  SR1, SR2;
  logic [63:0] RF_ONE, RF_TWO;
  logic        WB_V;
  logic [4:0]  WB_DR;
  logic [63:0] WB_DATA;
  logic        EX_STALL, FLUSH;
  logic        EX_V;
  logic [63:0] EX_PC;
  logic [31:0] EX_IR;
  logic [63:0] EX_OP1, EX_OP2, EX_IMM;
  logic [4:0]  EX_DR;
  logic        EX_WE;

  int n_cmp = 0;
  int n_err = 0;

  decode_stage #(.XLEN(64), .NREG(32)) dut (
    .CLK(CLK), .reset_n(reset_n), .FE_V(FE_V), .FE_IR(FE_IR), .FE_PC(FE_PC),
    .DE_STALL(DE_STALL), .SR1(SR1), .SR2(SR2), .RF_ONE(RF_ONE), .RF_TWO(RF_TWO),
    .WB_V(WB_V), .WB_DR(WB_DR), .WB_DATA(WB_DATA), .EX_STALL(EX_STALL), .FLUSH(FLUSH),
    .EX_V(EX_V), .EX_PC(EX_PC), .EX_IR(EX_IR), .EX_OP1(EX_OP1), .EX_OP2(EX_OP2),
    .EX_IMM(EX_IMM), .EX_DR(EX_DR), .EX_WE(EX_WE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic fe(input logic v, input logic [31:0] ir, input logic [63:0] pc);
    FE_V  = v;
    FE_IR = ir;
    FE_PC = pc;
    #1;
  endtask

  initial begin
    reset_n = 1'b0; FE_V = 1'b1; FE_IR = 32'h0070_0293; FE_PC = 64'h100;
    RF_ONE = 64'hDEAD; RF_TWO = 64'hBEEF;
    WB_V = 1'b0; WB_DR = '0; WB_DATA = '0; EX_STALL = 1'b0; FLUSH = 1'b0;

    // Reset with a valid instruction present
    tick(); tick();
    chk("rst_ex_v", 64'(EX_V), 64'h0);
    chk("rst_op1", EX_OP1, 64'h0);
    chk("rst_busy", 64'(dut.r_busy), 64'h0);

    // addi x5,x0,7 issues on the first edge after release
    reset_n = 1'b1; #1;
    chk("addi_nostall", 64'(DE_STALL), 64'h0);
    tick();
    chk("addi_v", 64'(EX_V), 64'h1);
    chk("addi_pc", EX_PC, 64'h100);
    chk("addi_imm", EX_IMM, 64'h7);
    chk("addi_dr", 64'(EX_DR), 64'h5);
    chk("addi_we", 64'(EX_WE), 64'h1);
    chk("addi_op1", EX_OP1, 64'h0);

    // add x6,x5,x5 stalls on busy x5 until writeback, then takes the bypass
    fe(1'b1, 32'h0052_8333, 64'h104);
    chk("raw_stall", 64'(DE_STALL), 64'h1);
    chk("raw_sr1", 64'(SR1), 64'h5);
    tick();
    chk("raw_bubble", 64'(EX_V), 64'h0);
    WB_V = 1'b1; WB_DR = 5'd5; WB_DATA = 64'h7; #1;
    chk("raw_release", 64'(DE_STALL), 64'h0);
    tick();
    WB_V = 1'b0;
    chk("add_v", 64'(EX_V), 64'h1);
    chk("add_op1", EX_OP1, 64'h7);
    chk("add_op2", EX_OP2, 64'h7);
    chk("add_we", 64'(EX_WE), 64'h1);
    chk("add_dr", 64'(EX_DR), 64'h6);
    chk("busy_5_6", 64'(dut.r_busy), 64'h40);

    // addi x0,x0,5 writes nothing
    fe(1'b1, 32'h0050_0013, 64'h108);
    tick();
    chk("x0_v", 64'(EX_V), 64'h1);
    chk("x0_we", 64'(EX_WE), 64'h0);
    chk("x0_imm", EX_IMM, 64'h5);
    chk("x0_busy", 64'(dut.r_busy), 64'h40);

    // add x1,x0,x0: no stall, operands forced to zero
    fe(1'b1, 32'h0000_00B3, 64'h10C);
    chk("x0src_nostall", 64'(DE_STALL), 64'h0);
    tick();
    chk("x0src_op1", EX_OP1, 64'h0);
    chk("x0src_op2", EX_OP2, 64'h0);
    chk("x0src_dr", 64'(EX_DR), 64'h1);

    // Retire x1 and x6 with no instruction presented
    fe(1'b0, 32'h0, 64'h0);
    WB_V = 1'b1; WB_DR = 5'd1; WB_DATA = 64'h0;
    tick();
    chk("idle_v", 64'(EX_V), 64'h0);
    WB_DR = 5'd6;
    tick();
    WB_V = 1'b0;
    chk("drain_busy", 64'(dut.r_busy), 64'h0);

    // beq x1,x2,-4
    RF_ONE = 64'h11; RF_TWO = 64'h22;
    fe(1'b1, 32'hFE20_8EE3, 64'h200);
    tick();
    chk("beq_imm", EX_IMM, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_op1", EX_OP1, 64'h11);
    chk("beq_op2", EX_OP2, 64'h22);
    chk("beq_we", 64'(EX_WE), 64'h0);

    // lui x3,0x80000
    fe(1'b1, 32'h8000_01B7, 64'h204);
    tick();
    chk("lui_imm", EX_IMM, 64'hFFFF_FFFF_8000_0000);
    chk("lui_op1", EX_OP1, 64'h0);
    chk("lui_dr", 64'(EX_DR), 64'h3);

    // EX_STALL for 3 cycles holds lui in EX; addi x7,x0,1 issues exactly once after
    fe(1'b1, 32'h0010_0393, 64'h208);
    EX_STALL = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("exs_destall", 64'(DE_STALL), 64'h1);
      tick();
      chk("exs_hold_dr", 64'(EX_DR), 64'h3);
      chk("exs_hold_v", 64'(EX_V), 64'h1);
    end
    chk("exs_busy", 64'(dut.r_busy), 64'h8);
    EX_STALL = 1'b0; #1;
    tick();
    chk("exs_issue_dr", 64'(EX_DR), 64'h7);
    chk("exs_issue_imm", EX_IMM, 64'h1);
    fe(1'b0, 32'h0, 64'h0);
    tick();
    chk("exs_once", 64'(EX_V), 64'h0);

    // FLUSH of a WAW-stalled addi x5 keeps the older writer's busy bit
    fe(1'b1, 32'h0070_0293, 64'h300);
    tick();
    chk("waw_first", 64'(EX_V), 64'h1);
    fe(1'b1, 32'h0090_0293, 64'h304);
    chk("waw_stall", 64'(DE_STALL), 64'h1);
    tick();
    chk("waw_bubble", 64'(EX_V), 64'h0);
    FLUSH = 1'b1; #1;
    chk("flush_destall", 64'(DE_STALL), 64'h0);
    tick();
    chk("flush_v", 64'(EX_V), 64'h0);
    chk("flush_busy5", 64'(dut.r_busy[5]), 64'h1);
    FLUSH = 1'b0;
    fe(1'b0, 32'h0, 64'h0);
    WB_V = 1'b1; WB_DR = 5'd5;
    tick();
    WB_V = 1'b0;
    chk("wb_clear5", 64'(dut.r_busy[5]), 64'h0);

    // WB to x0 never bypasses into an x0 source
    WB_V = 1'b1; WB_DR = 5'd0; WB_DATA = 64'h55;
    fe(1'b1, 32'h0000_00B3, 64'h400);
    tick();
    WB_V = 1'b0;
    chk("wbx0_op1", EX_OP1, 64'h0);

    // Reset overrides a held EX stage
    EX_STALL = 1'b1; reset_n = 1'b0; #1;
    tick();
    chk("rst_mid_v", 64'(EX_V), 64'h0);
    chk("rst_mid_busy", 64'(dut.r_busy), 64'h0);
    chk("rst_mid_dr", 64'(EX_DR), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV64I decode/issue stage between fetch and execute.
- Drives the register file read addresses SR1/SR2 combinationally from the fetched instruction, and takes in the register file's out_one/out_two.
- Generates the sign-extended immediate and tracks pending register writes in a 32-entry scoreboard.
- Stalls on hazards and latches one decoded instruction per cycle into the DE→EX pipeline register.

Parameters:
XLEN, 64, operand/PC/immediate width.
NREG, 32, architectural registers (scoreboard width).

Ports:
CLK  in  1  clock; all state updates on rising edge.
reset_n  in  1  synchronous active-low reset.
FE_V  in  1  fetched instruction valid.
FE_IR  in  32  fetched instruction.
FE_PC  in  XLEN  PC of FE_IR.
DE_STALL  out  1  fetch must hold FE_V/FE_IR/FE_PC.
SR1  out  5  register file read address A = FE_IR[19:15].
SR2  out  5  register file read address B = FE_IR[24:20].
RF_ONE  in  XLEN  register file out_one.
RF_TWO  in  XLEN  register file out_two.
WB_V  in  1  writeback valid; same signal drives register file ST_REG.
WB_DR  in  5  writeback destination.
WB_DATA  in  XLEN  writeback data.
EX_STALL  in  1  execute cannot accept; hold EX_* registers.
FLUSH  in  1  branch/jump redirect from execute; kill instruction at FE.
EX_V, EX_PC(XLEN), EX_IR(32), EX_OP1(XLEN), EX_OP2(XLEN), EX_IMM(XLEN), EX_DR(5), EX_WE(1)  out  registered decode results to execute.

Behaviour:
- Reset (reset_n=0 at edge): every EX_* output = 0, scoreboard busy[31:0] = 0. This overrides all other inputs, including mid-stall.
- Decode by opcode FE_IR[6:0], giving uses_rs1 (u1), uses_rs2 (u2), writes_rd (wr) and immediate format:
  - LUI 0110111 and AUIPC 0010111: wr, U.
  - JAL 1101111: wr, J.
  - JALR 1100111: u1, wr, I.
  - BRANCH 1100011: u1, u2, B.
  - LOAD 0000011: u1, wr, I.
  - STORE 0100011: u1, u2, S.
  - OP-IMM 0010011 and OP-IMM-32 0011011: u1, wr, I.
  - OP 0110011 and OP-32 0111011: u1, u2, wr, imm = 0.
  - Any other opcode: no register use, imm = 0.
- Immediate is sign-extended from FE_IR[31] to XLEN. U = {IR[31:12], 12'b0} sign-extended. B and J have bit 0 = 0.
- rd = FE_IR[11:7]. EX_WE = wr & (rd != 0).
- Operand select, for each source rs and its RF value:
  - rs == 0 → 0.
  - WB_V & WB_DR == rs & WB_DR != 0 → WB_DATA (bypass; the register file writes on the same edge).
  - Otherwise → RF value.
  - Unused sources → 0.
- Hazard, combinational: any of the following, where ready(r) = !busy[r] | (WB_V & WB_DR == r):
  - u1 & rs1 != 0 & !ready(rs1)
  - u2 & rs2 != 0 & !ready(rs2)
  - EX_WE-candidate & !ready(rd) (WAW)
- fire = FE_V & !EX_STALL & !FLUSH & !hazard.
- DE_STALL = FE_V & !FLUSH & (EX_STALL | hazard). Combinational, no registered delay.
- EX register update each edge, in priority order:
  - EX_STALL: hold all EX_* outputs.
  - Else fire: load decoded fields, EX_V = 1.
  - Else: EX_V = 0. Other EX_* fields don't care; implementation zeroes them.
- Latency: accepted instruction appears on EX_* exactly 1 cycle after the fire edge.
- Scoreboard per edge:
  - Clear busy[WB_DR] if WB_V.
  - Then set busy[rd] if fire & EX_WE. Set wins over clear on the same index.
  - busy[0] is always 0.
  - At most one outstanding writer per register, guaranteed by the WAW stall.
- FLUSH: the FE instruction is not issued and the scoreboard is not set. Older in-flight writers keep their busy bits.
- WB_V with WB_DR=0: no scoreboard or bypass effect.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with FE_V=1 → EX_V=0, EX_OP1=0, busy=0. Release → first valid instruction issues next cycle.
- RAW stall: issue addi x5,x0,7 (0x00700293), then add x6,x5,x5 (0x00528333) → DE_STALL=1 while busy[5]. Assert WB_V, WB_DR=5, WB_DATA=7 → add fires that cycle; next cycle EX_OP1=EX_OP2=7, EX_WE=1, EX_DR=6.
- x0 handling: addi x0,x0,5 (0x00500013) → EX_WE=0, busy unchanged. A following add x1,x0,x0 issues with no stall and operands 0, even if RF_ONE=0xDEAD.
- Immediate: beq x1,x2,-4 (0xFE208EE3) → EX_IMM=0xFFFF_FFFF_FFFF_FFFC. lui x3,0x80000 (0x800001B7) → EX_IMM=0xFFFF_FFFF_8000_0000.
- EX_STALL: hold EX_STALL=1 for 3 cycles with FE_V=1 → EX_* unchanged, DE_STALL=1, busy unchanged. On deassert the instruction issues once.
- FLUSH with WAW: busy[5]=1 and FE=addi x5 → stall. Assert FLUSH → DE_STALL=0, next EX_V=0, busy[5] still 1 until WB_V with WB_DR=5.
